// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bram_arb_pkg : shared types and rotate-priority helper for the BRAM arbiter
// Rev 1.0
// ------------------------------------------------------------------
package bram_arb_pkg;

  localparam int MAX_N = 8;

  typedef logic [MAX_N-1:0] req_vec_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // One-hot first set bit of mask at or after ptr, wrapping within n bits.
  function automatic req_vec_t rr_pick(input req_vec_t mask, input logic [2:0] ptr, input int n);
    req_vec_t pick;
    logic     found;
    int       idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && mask[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_port_arbiter_picker.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_priority_picker : combinational N-wide rotating priority selector
// Rev 1.0
// ------------------------------------------------------------------
module rr_priority_picker
  import bram_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  req_vec_t mask_ext;
  req_vec_t pick;
  logic     unused_pick;

  always_comb begin
    mask_ext        = '0;
    mask_ext[N-1:0] = mask;
    pick            = rr_pick(mask_ext, 3'(ptr), N);
    grant           = pick[N-1:0];
  end

  // Bits above N are always zero; folded here so nothing dangles.
  assign unused_pick = ^pick;

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// bram_port_arbiter : round-robin, burst-bounded sharing of one BRAM port
// Rev 1.0
// ------------------------------------------------------------------
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int  N         = 2,
  parameter int  W         = 32,
  parameter int  L         = 375,
  parameter int  MAX_BURST = 4,
  localparam int AW        = (L > 1) ? $clog2(L) : 1,
  localparam int CW        = W / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N-1:0]    req_we,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*CW-1:0] req_col,
  input  logic [N*W-1:0]  req_wdata,
  output logic [N-1:0]    rsp_valid,
  output logic [W-1:0]    rsp_data,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_wr_ena,
  output logic [CW-1:0]   ram_col_ena,
  output logic [W-1:0]    ram_wr_data,
  input  logic [W-1:0]    ram_rd_data
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [BW-1:0] burst_cnt;
  logic [AW-1:0] last_addr;

  logic [N-1:0]  owner_oh;
  logic [N-1:0]  pick_mask;
  logic [N-1:0]  picked;
  logic [N-1:0]  grant;
  logic [PW-1:0] pick_ptr;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] sel;
  logic          owner_valid;
  logic          others_valid;
  logic          keep_owner;
  logic          any_grant;

  always_comb begin
    owner_oh     = N'(1) << owner;
    owner_valid  = |(req_valid & owner_oh);
    others_valid = |(req_valid & ~owner_oh);
    next_ptr     = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
    // Owner keeps the port until its quota runs out, unless nobody else is waiting.
    keep_owner   = (state == BURST) && owner_valid &&
                   ((burst_cnt < BW'(MAX_BURST)) || !others_valid);
    if (state == BURST) begin
      pick_mask = req_valid & ~owner_oh;
      pick_ptr  = next_ptr;
    end else begin
      pick_mask = req_valid;
      pick_ptr  = rr_ptr;
    end
  end

  rr_priority_picker #(
    .N  (N),
    .PW (PW)
  ) u_picker (
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .grant (picked)
  );

  always_comb begin
    if (!rst_n)          grant = '0;
    else if (keep_owner) grant = owner_oh;
    else                 grant = picked;

    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel = PW'(i);
    end
    any_grant   = |grant;

    ram_addr    = any_grant ? req_addr[int'(sel)*AW +: AW] : last_addr;
    ram_wr_ena  = any_grant & req_we[sel];
    ram_col_ena = ram_wr_ena ? req_col[int'(sel)*CW +: CW] : '0;
    ram_wr_data = req_wdata[int'(sel)*W +: W];
  end

  assign req_ready = grant;
  assign rsp_data  = ram_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      last_addr <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= grant & ~req_we;
      if (any_grant) last_addr <= ram_addr;
      case (state)
        IDLE: begin
          if (any_grant) begin
            owner     <= sel;
            burst_cnt <= BW'(1);
            state     <= BURST;
          end
        end
        BURST: begin
          if (keep_owner) begin
            if (burst_cnt < BW'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
          end else if (any_grant) begin
            owner     <= sel;
            burst_cnt <= BW'(1);
            rr_ptr    <= next_ptr;
          end else begin
            state     <= IDLE;
            rr_ptr    <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_bram_port_arbiter : scoreboard bench with a behavioural arbiter/RAM model
// Rev 1.0
// ------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int L  = 375;
  localparam int MB = 4;
  localparam int AW = 9;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*CW-1:0] req_col;
  logic [N*W-1:0]  req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [W-1:0]    rsp_data;
  logic [AW-1:0]   ram_addr;
  logic            ram_wr_ena;
  logic [CW-1:0]   ram_col_ena;
  logic [W-1:0]    ram_wr_data;
  logic [W-1:0]    ram_rd_data;

  always #5 clk = ~clk;

  bram_port_arbiter #(.N(N), .W(W), .L(L), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_col     (req_col),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .ram_addr    (ram_addr),
    .ram_wr_ena  (ram_wr_ena),
    .ram_col_ena (ram_col_ena),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  // Byte-write block RAM with registered read data.
  logic [W-1:0] ram_mem [0:511];
  logic         ram_cleared = 1'b0;
  always @(posedge clk) begin
    if (!ram_cleared) begin
      for (int k = 0; k < 512; k++) ram_mem[k] <= '0;
      ram_cleared <= 1'b1;
    end else begin
      if (ram_wr_ena)
        for (int b = 0; b < CW; b++)
          if (ram_col_ena[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
      ram_rd_data <= ram_mem[ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int           id;
    int           due;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_q[$];

  // Reference model state: who owns the port, how long, where rotation resumes.
  logic [N-1:0] acc_seen = '0;
  bit           m_busy;
  int           m_owner, m_run, m_ptr;
  logic [AW-1:0] m_last;
  bit           m_last_known;
  logic [W-1:0] mmem [0:511];

  function automatic int model_pick();
    logic [N-1:0] others;
    int           s, j;
    if (!rst_n) return -1;
    others = req_valid;
    if (m_busy) others[m_owner] = 1'b0;
    if (m_busy && req_valid[m_owner] && (m_run < MB || others == '0)) return m_owner;
    s = m_busy ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++) begin
      j = (s + k) % N;
      if (others[j]) return j;
    end
    return -1;
  endfunction

  // Accept observer: checks grant and RAM drive, pushes read expectations.
  initial begin : observer
    int            g, act_g;
    logic [N-1:0]  exp_rdy;
    logic [AW-1:0] a;
    logic [CW-1:0] cl;
    logic [W-1:0]  wd;
    for (int k = 0; k < 512; k++) mmem[k] = '0;
    m_busy = 0; m_owner = 0; m_run = 0; m_ptr = 0; m_last = '0; m_last_known = 0;
    forever begin
      @(negedge clk);
      acc_seen = req_valid & req_ready;
      g = model_pick();
      act_g = -1;
      for (int k = 0; k < N; k++) if (req_ready[k]) act_g = k;
      gnt_q.push_back(act_g);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (g >= 0) begin
        a  = req_addr[g*AW +: AW];
        cl = req_col[g*CW +: CW];
        wd = req_wdata[g*W +: W];
        chk("ram_addr", ram_addr, a);
        chk("ram_wr_ena", ram_wr_ena, req_we[g]);
        if (req_we[g]) begin
          chk("ram_col_ena", ram_col_ena, cl);
          chk("ram_wr_data", ram_wr_data, wd);
          for (int b = 0; b < CW; b++) if (cl[b]) mmem[a][8*b +: 8] = wd[8*b +: 8];
        end else begin
          exp_q.push_back('{g, cyc + 1, mmem[a]});
        end
      end else begin
        chk("ram_wr_ena_idle", ram_wr_ena, 0);
        chk("ram_col_ena_idle", ram_col_ena, 0);
        if (m_last_known) chk("ram_addr_hold", ram_addr, m_last);
      end
      if (!rst_n) begin
        m_busy = 0; m_ptr = 0; m_run = 0; m_last_known = 0;
      end else if (g >= 0) begin
        if (m_busy && g == m_owner) begin
          if (m_run < MB) m_run++;
        end else begin
          m_owner = g;
          m_run   = 1;
        end
        m_busy = 1;
        m_last = a;
        m_last_known = 1;
      end else if (m_busy) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever any rsp_valid is seen.
  initial begin : monitor
    exp_t         e;
    logic [N-1:0] exp_v;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL rsp_missing: requester %0d due cycle %0d, none by cycle %0d", e.id, e.due, cyc);
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          exp_v = '0;
          exp_v[e.id] = 1'b1;
          chk("rsp_valid", rsp_valid, exp_v);
          chk("rsp_due", cyc, e.due);
          chk("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) tick();
  endtask

  // Each requester holds its beat until accepted, then draws a new one.
  task automatic gen_beats(input int p0, input int p1, input int p2, input bit rd_only, input int amax);
    int pct[N];
    int a;
    pct = '{p0, p1, p2};
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || acc_seen[i]) begin
        req_valid[i] = (int'($urandom_range(99)) < pct[i]);
        req_we[i]    = rd_only ? 1'b0 : 1'($urandom_range(1));
        a = int'($urandom_range(amax - 1));
        if ($urandom_range(19) == 0) a = L - 1;
        req_addr[i*AW +: AW]  = AW'(a);
        req_col[i*CW +: CW]   = CW'($urandom_range(15));
        req_wdata[i*W +: W]   = $urandom;
      end
    end
  endtask

  task automatic put_beat(input int i, input bit we, input int addr, input logic [3:0] col,
                          input logic [31:0] d);
    int t;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = AW'(addr);
    req_col[i*CW +: CW]  = col;
    req_wdata[i*W +: W]  = d;
    req_valid[i]         = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (!acc_seen[i] && t < 50);
    chk("put_beat_accept", acc_seen[i], 1);
    req_valid[i] = 1'b0;
  endtask

  initial begin : stim
    int n;
    int p[N];
    int pt[4];
    int seq_a[9];
    int seq_b[12];
    pt    = '{0, 30, 70, 100};
    seq_a = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    seq_b = '{2, 2, 2, 2, 0, 0, 0, 0, 2, 2, 2, 2};
    req_valid = '1;
    req_we    = '0;
    req_addr  = '0;
    req_col   = '0;
    req_wdata = '0;
    rst_n     = 1'b0;
    repeat (3) tick();
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    req_valid = '0;
    rst_n = 1'b1;
    idle(1);

    put_beat(0, 1'b1, 5, 4'hF, 32'hDEADBEEF);
    put_beat(0, 1'b0, 5, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd5_rsp_valid", rsp_valid, 3'b001);
    chk("rd5_rsp_data", rsp_data, 32'hDEADBEEF);
    tick();

    put_beat(0, 1'b1, 7, 4'hF, 32'h11223344);
    put_beat(0, 1'b1, 7, 4'b0101, 32'hAABBCCDD);
    put_beat(0, 1'b0, 7, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd7_rsp_valid", rsp_valid, 3'b001);
    chk("rd7_rsp_data", rsp_data, 32'h11BB33DD);
    tick();

    idle(2);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      gen_beats(0, 100, 0, 1'b1, L);
      tick();
      if (acc_seen[1]) n++;
    end
    chk("lone_accepts", n, 20);
    idle(2);

    for (int k = 0; k < 2; k++) begin
      gen_beats(100, 0, 0, 1'b1, 16);
      tick();
    end
    gen_beats(100, 0, 0, 1'b1, 16);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    gnt_q.delete();
    gen_beats(100, 100, 0, 1'b0, 16);
    @(negedge clk);
    chk("killed_rd_rsp", rsp_valid, 0);
    tick();
    for (int k = 0; k < 16; k++) begin
      gen_beats(100, 100, 0, 1'b0, 16);
      tick();
    end
    for (int k = 0; k < 9; k++) chk("contention_seq", gnt_q[k], seq_a[k]);

    idle(2);
    gnt_q.delete();
    for (int k = 0; k < 12; k++) begin
      gen_beats(100, 0, 100, 1'b0, 16);
      tick();
    end
    for (int k = 0; k < 12; k++) chk("skip_seq", gnt_q[k], seq_b[k]);
    idle(2);

    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) p[i] = pt[$urandom_range(3)];
      for (int k = 0; k < 50; k++) begin
        gen_beats(p[0], p[1], p[2], 1'b0, 16);
        tick();
      end
    end
    idle(4);
    chk("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
